// File: rtl/xnor_correlator.sv
// Serial XNOR correlator. Bits shift into a WIDTH-bit window that is scored against a latched pattern.
// The block flags threshold hits and keeps a saturating count of them.
module xnor_correlator #(
  parameter int WIDTH  = 8,
  parameter int THRESH = WIDTH,
  parameter int CW     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           din,
  input  logic                           din_valid,
  input  logic                           load,
  input  logic [WIDTH-1:0]               pattern,
  input  logic                           clear,
  output logic [$clog2(WIDTH+1)-1:0]     score,
  output logic                           score_valid,
  output logic                           hit,
  output logic [CW-1:0]                  hit_count
);
  localparam int SW = $clog2(WIDTH+1);
  localparam logic [SW-1:0] THR  = SW'(THRESH);
  localparam logic [SW-1:0] FULL = SW'(WIDTH);

  typedef enum logic {FILL, RUN} state_t;
  state_t state;

  logic [WIDTH-1:0] pat_r, win, win_next, xn;
  logic [SW-1:0]    fill, fill_next, agree;
  logic             sv_next;

  always_comb begin
    win_next = {win[WIDTH-2:0], din};
    xn       = ~(win_next ^ pat_r);
    agree    = '0;
    for (int i = 0; i < WIDTH; i++) agree = agree + {{(SW-1){1'b0}}, xn[i]};
    fill_next = (state == RUN) ? FULL : fill + 1'b1;
    sv_next   = (fill_next == FULL);
  end

  // load outranks din_valid: a bit presented with load is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_r       <= '0;
      win         <= '0;
      fill        <= '0;
      state       <= FILL;
      score       <= '0;
      score_valid <= 1'b0;
      hit         <= 1'b0;
    end else if (load) begin
      pat_r       <= pattern;
      win         <= '0;
      fill        <= '0;
      state       <= FILL;
      score       <= '0;
      score_valid <= 1'b0;
      hit         <= 1'b0;
    end else if (din_valid) begin
      win         <= win_next;
      fill        <= fill_next;
      score       <= agree;
      score_valid <= sv_next;
      hit         <= sv_next && (agree >= THR);
      if (state == FILL && sv_next) state <= RUN;
    end else begin
      hit <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          hit_count <= '0;
    else if (clear)                      hit_count <= '0;
    else if (hit && hit_count != '1)     hit_count <= hit_count + 1'b1;
  end
endmodule
